// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer_if
//  Description : Bundle of allocation, completion and retirement signals
//                between rename/execute (master) and the reorder buffer
//                (slave). Adds retired_total when ROB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
   parameter int DEPTH = 16,
   parameter int IDXW  = $clog2(DEPTH)
);

   // allocation from rename (older = 1, younger = 2)
   logic            alloc1_valid;
   logic [4:0]      alloc1_rd;
   logic [5:0]      alloc1_pd;
   logic [5:0]      alloc1_old_pd;
   logic            alloc2_valid;
   logic [4:0]      alloc2_rd;
   logic [5:0]      alloc2_pd;
   logic [5:0]      alloc2_old_pd;
   logic            alloc_ready;
   logic [IDXW-1:0] alloc1_idx;
   logic [IDXW-1:0] alloc2_idx;

   // completion from execution
   logic            cmpl1_valid;
   logic [IDXW-1:0] cmpl1_idx;
   logic            cmpl2_valid;
   logic [IDXW-1:0] cmpl2_idx;

   // retirement / free-list return
   logic [5:0]      regFree1;
   logic [5:0]      regFree2;
   logic            regFree1_valid;
   logic            regFree2_valid;
   logic [1:0]      ret_count;

   // occupancy
   logic [IDXW:0]   rob_count;
   logic            rob_empty;
   logic            rob_full;

`ifdef ROB_STATS_EN
   logic [31:0]     retired_total;
`endif

   modport master (
      output alloc1_valid, alloc1_rd, alloc1_pd, alloc1_old_pd,
      output alloc2_valid, alloc2_rd, alloc2_pd, alloc2_old_pd,
      output cmpl1_valid, cmpl1_idx, cmpl2_valid, cmpl2_idx,
      input  alloc_ready, alloc1_idx, alloc2_idx,
      input  regFree1, regFree2, regFree1_valid, regFree2_valid, ret_count,
`ifdef ROB_STATS_EN
      input  retired_total,
`endif
      input  rob_count, rob_empty, rob_full
   );

   modport slave (
      input  alloc1_valid, alloc1_rd, alloc1_pd, alloc1_old_pd,
      input  alloc2_valid, alloc2_rd, alloc2_pd, alloc2_old_pd,
      input  cmpl1_valid, cmpl1_idx, cmpl2_valid, cmpl2_idx,
      output alloc_ready, alloc1_idx, alloc2_idx,
      output regFree1, regFree2, regFree1_valid, regFree2_valid, ret_count,
`ifdef ROB_STATS_EN
      output retired_total,
`endif
      output rob_count, rob_empty, rob_full
   );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Two-wide in-order-retire reorder buffer. Records rename
//                mappings, collects out-of-order completions and retires up
//                to two done entries per cycle, returning old_pd to the
//                free list. Optional macro ROB_STATS_EN adds a 32-bit
//                retired_total counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   reorder_buffer_if.slave  rob
);

   localparam int IDXW        = $clog2(DEPTH);
   localparam int c_READY_MAX = DEPTH - 2;

   // ---------------------------------------------------------------------
   // Entry storage and pointers
   // ---------------------------------------------------------------------
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_done;
   logic [4:0]       r_rd     [DEPTH];
   logic [5:0]       r_pd     [DEPTH];
   logic [5:0]       r_old_pd [DEPTH];
   logic [IDXW-1:0]  r_head;
   logic [IDXW-1:0]  r_tail;
   logic [IDXW:0]    r_count;

   // registered retirement outputs
   logic [5:0]       r_free1;
   logic [5:0]       r_free2;
   logic             r_free1_valid;
   logic             r_free2_valid;
   logic [1:0]       r_ret_count;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic             w_alloc_ready;
   logic             w_alloc1;
   logic             w_alloc2;
   logic [IDXW-1:0]  w_tail1;
   logic [IDXW-1:0]  w_head1;
   logic             w_ret1;
   logic             w_ret2;
   logic [1:0]       w_n_alloc;
   logic [1:0]       w_n_ret;
   logic             w_free1_valid;
   logic             w_free2_valid;

   // per-entry strobes
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_sel2;
   logic [DEPTH-1:0] w_cmpl;
   logic [DEPTH-1:0] w_clr;

   // pd travels with the entry for observability of the retiring mapping;
   // the free list itself only needs old_pd
   logic             w_unused_ret_pd;

   // Occupancy status and allocation gating come only from registered state
   assign w_alloc_ready = (r_count <= (IDXW+1)'(c_READY_MAX));
   assign w_alloc1      = rob.alloc1_valid & w_alloc_ready;
   // the younger slot is only honoured alongside the older one
   assign w_alloc2      = w_alloc1 & rob.alloc2_valid;
   assign w_tail1       = r_tail + IDXW'(1);
   assign w_head1       = r_head + IDXW'(1);

   // Retirement looks at state before the edge; head+1 only follows head
   assign w_ret1        = r_valid[r_head] & r_done[r_head];
   assign w_ret2        = w_ret1 & r_valid[w_head1] & r_done[w_head1];

   assign w_n_alloc     = {1'b0, w_alloc1} + {1'b0, w_alloc2};
   assign w_n_ret       = {1'b0, w_ret1} + {1'b0, w_ret2};

   // x0 writes and the x0 physical register are never returned
   assign w_free1_valid = w_ret1 & (r_rd[r_head] != 5'd0)
                                 & (r_old_pd[r_head] != 6'd0);
   assign w_free2_valid = w_ret2 & (r_rd[w_head1] != 5'd0)
                                 & (r_old_pd[w_head1] != 6'd0);

   assign w_unused_ret_pd = ^{r_pd[r_head], r_pd[w_head1]};

   // Decode allocation, completion and retirement onto each entry
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign w_sel2[i] = w_alloc2 & (w_tail1 == IDXW'(i));
      assign w_set[i]  = (w_alloc1 & (r_tail == IDXW'(i))) | w_sel2[i];
      assign w_cmpl[i] = (rob.cmpl1_valid & (rob.cmpl1_idx == IDXW'(i)))
                       | (rob.cmpl2_valid & (rob.cmpl2_idx == IDXW'(i)));
      assign w_clr[i]  = (w_ret1 & (r_head  == IDXW'(i)))
                       | (w_ret2 & (w_head1 == IDXW'(i)));
   end

   // ---------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------

   // Entry status: allocation wins over a same-edge completion, retirement
   // clears, completion only marks entries that are already live
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_done  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_set[i]) begin
               r_valid[i] <= 1'b1;
               r_done[i]  <= 1'b0;
            end else if (w_clr[i]) begin
               r_valid[i] <= 1'b0;
               r_done[i]  <= 1'b0;
            end else if (w_cmpl[i] && r_valid[i]) begin
               r_done[i]  <= 1'b1;
            end
         end
      end
   end

   // Entry payload is only meaningful while valid, so it needs no reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_set[i]) begin
            if (w_sel2[i]) begin
               r_rd[i]     <= rob.alloc2_rd;
               r_pd[i]     <= rob.alloc2_pd;
               r_old_pd[i] <= rob.alloc2_old_pd;
            end else begin
               r_rd[i]     <= rob.alloc1_rd;
               r_pd[i]     <= rob.alloc1_pd;
               r_old_pd[i] <= rob.alloc1_old_pd;
            end
         end
      end
   end

   // Pointers and occupancy advance by the number allocated / retired
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + IDXW'(w_n_ret);
         r_tail  <= r_tail + IDXW'(w_n_alloc);
         r_count <= r_count + (IDXW+1)'(w_n_alloc) - (IDXW+1)'(w_n_ret);
      end
   end

   // Free-list return strobes, one cycle per retirement; older slot first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_free1       <= '0;
         r_free2       <= '0;
         r_free1_valid <= 1'b0;
         r_free2_valid <= 1'b0;
         r_ret_count   <= '0;
      end else begin
         r_free1       <= w_free1_valid ? r_old_pd[r_head]  : 6'd0;
         r_free2       <= w_free2_valid ? r_old_pd[w_head1] : 6'd0;
         r_free1_valid <= w_free1_valid;
         r_free2_valid <= w_free2_valid;
         r_ret_count   <= w_n_ret;
      end
   end

`ifdef ROB_STATS_EN
   logic [31:0] r_retired_total;

   // Running total of retirements; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired_total <= '0;
      end else begin
         r_retired_total <= r_retired_total + 32'(w_n_ret);
      end
   end

   assign rob.retired_total = r_retired_total;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign rob.alloc_ready    = w_alloc_ready;
   assign rob.alloc1_idx     = r_tail;
   assign rob.alloc2_idx     = w_tail1;
   assign rob.regFree1       = r_free1;
   assign rob.regFree2       = r_free2;
   assign rob.regFree1_valid = r_free1_valid;
   assign rob.regFree2_valid = r_free2_valid;
   assign rob.ret_count      = r_ret_count;
   assign rob.rob_count      = r_count;
   assign rob.rob_empty      = (r_count == '0);
   assign rob.rob_full       = (r_count == (IDXW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer. A small occupancy
//                model predicts status and retire counts; expected free-list
//                returns are queued at allocation and popped on retirement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

   localparam int DEPTH = 16;
   localparam int IDXW  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   reorder_buffer_if #(.DEPTH(DEPTH)) rob_if ();

   reorder_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rob   (rob_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [4:0] rd;
      logic [5:0] old_pd;
   } free_t;

   free_t exp_q[$];

   bit m_valid [DEPTH];
   bit m_done  [DEPTH];
   int m_head  = 0;
   int m_tail  = 0;
   int m_count = 0;
   int seq     = 1;

   // Single comparison point
   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic idle_inputs();
      rob_if.alloc1_valid  = 1'b0;
      rob_if.alloc1_rd     = '0;
      rob_if.alloc1_pd     = '0;
      rob_if.alloc1_old_pd = '0;
      rob_if.alloc2_valid  = 1'b0;
      rob_if.alloc2_rd     = '0;
      rob_if.alloc2_pd     = '0;
      rob_if.alloc2_old_pd = '0;
      rob_if.cmpl1_valid   = 1'b0;
      rob_if.cmpl1_idx     = '0;
      rob_if.cmpl2_valid   = 1'b0;
      rob_if.cmpl2_idx     = '0;
   endtask

   task automatic set_alloc(input bit v1, input logic [4:0] rd1,
                            input logic [5:0] pd1, input logic [5:0] old1,
                            input bit v2, input logic [4:0] rd2,
                            input logic [5:0] pd2, input logic [5:0] old2);
      rob_if.alloc1_valid  = v1;
      rob_if.alloc1_rd     = rd1;
      rob_if.alloc1_pd     = pd1;
      rob_if.alloc1_old_pd = old1;
      rob_if.alloc2_valid  = v2;
      rob_if.alloc2_rd     = rd2;
      rob_if.alloc2_pd     = pd2;
      rob_if.alloc2_old_pd = old2;
   endtask

   task automatic alloc_pair();
      set_alloc(1'b1, 5'(1 + seq % 31), 6'(seq % 64), 6'(1 + (seq * 7) % 63),
                1'b1, 5'(1 + (seq + 1) % 31), 6'((seq + 1) % 64),
                6'(1 + ((seq + 1) * 7) % 63));
      seq += 2;
   endtask

   task automatic set_cmpl(input bit v1, input int i1, input bit v2, input int i2);
      rob_if.cmpl1_valid = v1;
      rob_if.cmpl1_idx   = IDXW'(i1);
      rob_if.cmpl2_valid = v2;
      rob_if.cmpl2_idx   = IDXW'(i2);
   endtask

   // One clock: check status, advance model, then check retirement output
   task automatic tick();
      bit a1, a2, r1, r2;
      int h1, nret;
      free_t e;
      bit ev;
      check_val("alloc_ready", rob_if.alloc_ready, 32'(m_count <= DEPTH - 2));
      check_val("alloc1_idx", rob_if.alloc1_idx, 32'(m_tail));
      check_val("alloc2_idx", rob_if.alloc2_idx, 32'((m_tail + 1) % DEPTH));
      check_val("rob_count", rob_if.rob_count, 32'(m_count));
      check_val("rob_empty", rob_if.rob_empty, 32'(m_count == 0));
      check_val("rob_full", rob_if.rob_full, 32'(m_count == DEPTH));

      a1 = rob_if.alloc1_valid && (m_count <= DEPTH - 2);
      a2 = a1 && rob_if.alloc2_valid;
      h1 = (m_head + 1) % DEPTH;
      r1 = m_valid[m_head] && m_done[m_head];
      r2 = r1 && m_valid[h1] && m_done[h1];
      if (a1) exp_q.push_back('{rob_if.alloc1_rd, rob_if.alloc1_old_pd});
      if (a2) exp_q.push_back('{rob_if.alloc2_rd, rob_if.alloc2_old_pd});
      if (rob_if.cmpl1_valid && m_valid[rob_if.cmpl1_idx]) m_done[rob_if.cmpl1_idx] = 1'b1;
      if (rob_if.cmpl2_valid && m_valid[rob_if.cmpl2_idx]) m_done[rob_if.cmpl2_idx] = 1'b1;
      if (r1) begin m_valid[m_head] = 1'b0; m_done[m_head] = 1'b0; end
      if (r2) begin m_valid[h1] = 1'b0; m_done[h1] = 1'b0; end
      if (a1) begin m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0; end
      if (a2) begin m_valid[(m_tail + 1) % DEPTH] = 1'b1; m_done[(m_tail + 1) % DEPTH] = 1'b0; end
      m_head  = (m_head + int'(r1) + int'(r2)) % DEPTH;
      m_tail  = (m_tail + int'(a1) + int'(a2)) % DEPTH;
      m_count = m_count + int'(a1) + int'(a2) - int'(r1) - int'(r2);

      @(posedge clk);
      #1;
      idle_inputs();

      check_val("ret_count", rob_if.ret_count, 32'(int'(r1) + int'(r2)));
      nret = int'(rob_if.ret_count);
      if (nret < 1) check_val("free1_idle", rob_if.regFree1_valid, 0);
      if (nret < 2) check_val("free2_idle", rob_if.regFree2_valid, 0);
      for (int k = 0; k < nret && k < 2; k++) begin
         if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(k), 32'(k + 1));
         end else begin
            e  = exp_q.pop_front();
            ev = (e.rd != 5'd0) && (e.old_pd != 6'd0);
            if (k == 0) begin
               check_val("free1_valid", rob_if.regFree1_valid, 32'(ev));
               if (ev) check_val("free1_pd", rob_if.regFree1, 32'(e.old_pd));
            end else begin
               check_val("free2_valid", rob_if.regFree2_valid, 32'(ev));
               if (ev) check_val("free2_pd", rob_if.regFree2, 32'(e.old_pd));
            end
         end
      end
   endtask

   // Complete outstanding entries two at a time until the ROB empties
   task automatic drain();
      int found [2];
      int nf, idx;
      for (int it = 0; it < 3 * DEPTH && m_count > 0; it++) begin
         nf = 0;
         for (int j = 0; j < m_count && nf < 2; j++) begin
            idx = (m_head + j) % DEPTH;
            if (m_valid[idx] && !m_done[idx]) begin
               found[nf] = idx;
               nf++;
            end
         end
         set_cmpl(nf > 0, (nf > 0) ? found[0] : 0, nf > 1, (nf > 1) ? found[1] : 0);
         tick();
      end
      check_val("drain_empty", rob_if.rob_empty, 1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_done[i]  = 1'b0;
      end
      m_head  = 0;
      m_tail  = 0;
      m_count = 0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ret_count", rob_if.ret_count, 0);
      check_val("rst_free1_valid", rob_if.regFree1_valid, 0);
      check_val("rst_free2_valid", rob_if.regFree2_valid, 0);
      check_val("rst_empty", rob_if.rob_empty, 1);
      check_val("rst_alloc1_idx", rob_if.alloc1_idx, 0);
      rst_n = 1'b1;

      // Out-of-order completion, in-order retirement
      set_alloc(1'b1, 5'd5, 6'd32, 6'd5, 1'b1, 5'd6, 6'd33, 6'd6);
      tick();
      set_cmpl(1'b1, 1, 1'b0, 0);
      tick();
      check_val("t1_wait_idx1", rob_if.ret_count, 0);
      set_cmpl(1'b1, 0, 1'b0, 0);
      tick();
      check_val("t1_wait_idx0", rob_if.ret_count, 0);
      tick();
      check_val("t1_ret", rob_if.ret_count, 2);
      check_val("t1_free1", rob_if.regFree1, 5);
      check_val("t1_free2", rob_if.regFree2, 6);

      // x0 destination is not returned
      set_alloc(1'b1, 5'd0, 6'd0, 6'd0, 1'b1, 5'd7, 6'd34, 6'd7);
      tick();
      set_cmpl(1'b1, 2, 1'b1, 3);
      tick();
      tick();
      check_val("t2_ret", rob_if.ret_count, 2);
      check_val("t2_free1_valid", rob_if.regFree1_valid, 0);
      check_val("t2_free2", rob_if.regFree2, 7);
      check_val("t2_free2_valid", rob_if.regFree2_valid, 1);

      // Fill to full, drop extra allocations, wrap the tail
      for (int p = 0; p < 8; p++) begin
         alloc_pair();
         tick();
      end
      check_val("t3_full", rob_if.rob_full, 1);
      check_val("t3_ready_full", rob_if.alloc_ready, 0);
      alloc_pair();
      tick();
      check_val("t3_drop_count", rob_if.rob_count, 16);
      set_cmpl(1'b1, m_head, 1'b1, (m_head + 1) % DEPTH);
      tick();
      tick();
      check_val("t3_ready_back", rob_if.alloc_ready, 1);
      check_val("t3_count14", rob_if.rob_count, 14);
      set_alloc(1'b1, 5'd9, 6'd50, 6'd41, 1'b0, 5'd0, 6'd0, 6'd0);
      tick();
      check_val("t3_ready15", rob_if.alloc_ready, 0);
      check_val("t3_idx_wrap", rob_if.alloc1_idx, 5);
      alloc_pair();
      tick();
      check_val("t3_drop15", rob_if.rob_count, 15);
      drain();

      // Completion to an invalid entry on an empty ROB
      set_cmpl(1'b1, 9, 1'b0, 0);
      tick();
      check_val("t5_empty", rob_if.rob_empty, 1);
      tick();
      check_val("t5_no_ret", rob_if.ret_count, 0);

      // Completion at the same edge as allocation of that index is lost
      set_cmpl(1'b1, m_tail, 1'b1, (m_tail + 1) % DEPTH);
      alloc_pair();
      tick();
      tick();
      check_val("t5_alloc_wins", rob_if.ret_count, 0);
      drain();

      // Allocate, complete and retire in the same cycle
      alloc_pair();
      tick();
      alloc_pair();
      tick();
      set_cmpl(1'b1, m_head, 1'b1, (m_head + 1) % DEPTH);
      tick();
      alloc_pair();
      set_cmpl(1'b1, (m_head + 2) % DEPTH, 1'b1, (m_head + 3) % DEPTH);
      tick();
      check_val("t4_count_same", rob_if.rob_count, 4);
      check_val("t4_ret", rob_if.ret_count, 2);
      tick();
      drain();

      // Asynchronous reset with entries in flight
      for (int p = 0; p < 6; p++) begin
         alloc_pair();
         tick();
      end
      set_cmpl(1'b1, m_head, 1'b1, (m_head + 1) % DEPTH);
      tick();
      tick();
      check_val("t6_count10", rob_if.rob_count, 10);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_free1_valid", rob_if.regFree1_valid, 0);
      check_val("t6_free2_valid", rob_if.regFree2_valid, 0);
      check_val("t6_free1", rob_if.regFree1, 0);
      check_val("t6_ret_count", rob_if.ret_count, 0);
      check_val("t6_count", rob_if.rob_count, 0);
      check_val("t6_empty", rob_if.rob_empty, 1);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("t6_idx_after", rob_if.alloc1_idx, 0);
      alloc_pair();
      tick();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
# reorder_buffer

Two-wide in-order-retire reorder buffer sitting directly downstream of the register-rename stage. It records each renamed instruction's destination mapping (rd, pd, old_pd), collects out-of-order completion notifications from execution, and retires up to two completed instructions per cycle in program order. On retirement it returns the superseded physical register (old_pd) to rename's free list through the `regFree1/regFree2` ports.

## Interface
- `DEPTH`, 16, number of entries; power of two, 4..64
- `IDXW`, $clog2(DEPTH), entry index width (derived; do not override)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alloc1_valid`  in  1  allocate slot for older renamed instruction
- `alloc1_rd`  in  5  architectural destination
- `alloc1_pd`  in  6  new physical destination
- `alloc1_old_pd`  in  6  previous mapping of rd
- `alloc2_valid`, `alloc2_rd`, `alloc2_pd`, `alloc2_old_pd`  in  1/5/6/6  same fields for the younger instruction
- `alloc_ready`  out  1  at least two free entries
- `alloc1_idx`, `alloc2_idx`  out  IDXW  entry indices that the current allocations will receive (tail, tail+1)
- `cmpl1_valid`, `cmpl1_idx`  in  1/IDXW  completion port 1
- `cmpl2_valid`, `cmpl2_idx`  in  1/IDXW  completion port 2
- `regFree1`, `regFree2`  out  6  physical register released by retirement
- `regFree1_valid`, `regFree2_valid`  out  1  release strobes
- `ret_count`  out  2  instructions retired at last edge (0..2)
- `rob_count`  out  IDXW+1  occupied entries
- `rob_empty`, `rob_full`  out  1  count==0 / count==DEPTH

## Operation
- Circular buffer; head and tail pointers IDXW bits, wrap naturally modulo DEPTH. Per entry: valid, done, rd, pd, old_pd.
- Allocation: accepted only when `alloc_ready`. `alloc1` writes at tail; `alloc2` writes at tail+1 and is honoured only if `alloc1_valid` is also high (`alloc2` alone is ignored). Tail advances by the number accepted. Allocation attempts while `alloc_ready` is low are dropped without state change; upstream must stall.
- New entry: valid=1, done=0.
- Completion: sets done on the indexed entry if valid; completion to an invalid entry is ignored. Both ports may target the same entry (idempotent).
- Retirement, evaluated on state before the edge: head retires if valid&done; head+1 retires only if head retires and head+1 is valid&done. Retired entries are cleared (valid=0, done=0), and head advances by `ret_count`.
- Free return: for each retiring entry with rd != 0 and old_pd != 0, the slot's `regFreeN` gets old_pd with `regFreeN_valid`=1. Older retiree uses slot 1 and younger uses slot 2. Otherwise that slot's valid is 0.
- Simultaneous alloc/complete/retire in one cycle all apply. `rob_count` = count + allocs − retires.
- Same-edge completion to an index being allocated: allocation wins and done=0.

## Timing
- `alloc_ready`, `alloc1_idx`, `alloc2_idx`, `rob_empty`, `rob_full`, `rob_count`: combinational from registered state only, with no input-to-output path.
- `regFree*`, `regFree*_valid`, `ret_count`: registered; asserted for exactly one cycle per retirement.
- Latency: allocation at edge A lets completion land at edge ≥A+1, which makes retirement at the next edge and `regFree` visible after it. Minimum alloc-to-free is 2 cycles.
- Reset (async, any time including mid-operation): all entries invalid, head=tail=0, count=0, `regFree*`=0, `regFree*_valid`=0, `ret_count`=0. Outputs go to these values immediately on `rst_n` low.

## Configuration
- `ROB_STATS_EN` defined: adds output `retired_total` (32 bits, reset 0), which increments by `ret_count` each edge and wraps at 2^32.
- `ROB_STATS_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset then allocate 2 (rd=5,pd=32,old=5; rd=6,pd=33,old=6), complete idx1 then idx0. Required: no free until idx0 done, then one edge later regFree1=5/valid, regFree2=6/valid, ret_count=2.
- Allocate rd=0 (pd=0) and rd=7 (old=7), then complete both. Required: retire 2, regFree1_valid=0, regFree2=7 valid.
- Fill DEPTH=16 with pairs. Required: alloc_ready=0 at count=15 and 16, and an extra alloc is dropped with count unchanged. Retiring 2 restores ready, and tail wraps 15→0 correctly.
- Same cycle: alloc 2, complete head pair, retire head pair. Required: count unchanged and the correct old_pd values returned.
- Complete invalid index 9 on an empty ROB. Required: no state change, rob_empty stays 1.
- Assert rst_n low mid-stream with 10 entries. Required: outputs zero immediately, and after release alloc1_idx=0.
